// File: rtl/dmem_resp_pkg.sv
// Shared definitions for the data-memory responder: bus widths, default
// storage depth, the responder state encoding and a small address helper.
package dmem_resp_pkg;

  localparam int DATA_W        = 16;
  localparam int ADDR_W        = 7;
  localparam int DEFAULT_DEPTH = 64;
  localparam int CNT_W         = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  // True when a word address falls inside a storage array of 'depth' words.
  function automatic logic addr_in_range(input logic [ADDR_W-1:0] a, input int depth);
    return int'(a) < depth;
  endfunction

endpackage

// File: rtl/dmem_resp_array.sv
// Storage array for the data-memory responder: one synchronous write port
// and one combinational read port. Contents are never cleared by reset.
module dmem_resp_array
  import dmem_resp_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [IDX_W-1:0]  rd_idx,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Commit a store on the clock edge when the write strobe is high.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_idx] <= wr_data;
    end
  end

  assign rd_data = mem[rd_idx];

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: captures one load/store request, inserts
// WAIT_CYCLES wait states, then answers with a one-cycle ack.
// Optional feature: define DMEM_RESP_ERR_EN to add the err port and flag
// out-of-range addresses instead of aliasing them modulo DEPTH.
module dmem_responder
  import dmem_resp_pkg::*;
#(
  parameter int WAIT_CYCLES = 2,
  parameter int DEPTH       = DEFAULT_DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              ack,
  output logic [DATA_W-1:0] rdata,
  output logic              busy
`ifdef DMEM_RESP_ERR_EN
  ,
  output logic              err
`endif
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  state_t            state_q;
  state_t            state_d;
  logic [CNT_W-1:0]  cnt_q;
  logic [ADDR_W-1:0] addr_q;
  logic              we_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q;
  logic              err_q;

  logic              capture;
  logic [ADDR_W-1:0] cur_addr;
  logic              cur_we;
  logic              cur_err;
  logic              wr_en;
  logic [IDX_W-1:0]  rd_idx;
  logic [IDX_W-1:0]  wr_idx;
  logic [DATA_W-1:0] mem_rdata;

  // Reduce a word address onto the storage array.
  function automatic logic [IDX_W-1:0] to_index(input logic [ADDR_W-1:0] a);
    return IDX_W'(int'(a) % DEPTH);
  endfunction

  assign capture  = (state_q == IDLE) && req;

  // With WAIT_CYCLES=0 the response follows capture directly, so the read
  // path has to look at the live request rather than the latched copy.
  assign cur_addr = (state_q == IDLE) ? addr : addr_q;
  assign cur_we   = (state_q == IDLE) ? we   : we_q;

`ifdef DMEM_RESP_ERR_EN
  assign cur_err  = !addr_in_range(cur_addr, DEPTH);
`else
  assign cur_err  = 1'b0;
`endif

  assign rd_idx   = to_index(cur_addr);
  assign wr_idx   = to_index(addr_q);

  // A store lands on the edge closing RESP unless it was an error or reset hits.
  assign wr_en    = (state_q == RESP) && we_q && !err_q && rst;

  dmem_resp_array #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_array (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_idx  (wr_idx),
    .wr_data (wdata_q),
    .rd_idx  (rd_idx),
    .rd_data (mem_rdata)
  );

  // State register; reset aborts whatever transaction is in flight.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: requests are only looked at while idle.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (req) begin
          state_d = (WAIT_CYCLES == 0) ? RESP : WAIT;
        end
      end
      WAIT: begin
        if (cnt_q <= CNT_W'(1)) begin
          state_d = RESP;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Request latches, wait counter and response registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q   <= '0;
      addr_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      if (capture) begin
        addr_q  <= addr;
        we_q    <= we;
        wdata_q <= wdata;
        cnt_q   <= CNT_W'(WAIT_CYCLES);
      end else if ((state_q == WAIT) && (cnt_q != '0)) begin
        cnt_q <= cnt_q - 1'b1;
      end

      if (state_d == RESP) begin
        err_q <= cur_err;
        if (cur_err) begin
          rdata_q <= '0;
        end else if (!cur_we) begin
          rdata_q <= mem_rdata;
        end
      end else if (state_q == RESP) begin
        err_q <= 1'b0;
      end
    end
  end

  assign ack   = (state_q == RESP);
  assign busy  = (state_q != IDLE);
  assign rdata = rdata_q;

`ifdef DMEM_RESP_ERR_EN
  assign err   = err_q;
`endif

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have parameter WAIT_CYCLES, default 2, meaning the number of wait-state cycles inserted between request capture and response (legal range 0..15).
REQ-002 SHALL have parameter DEPTH, default 64, meaning the number of 16-bit storage words.
REQ-003 SHALL have port clk  input  1  single system clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-low.
REQ-005 SHALL have port req  input  1  request strobe from the processor-side initiator.
REQ-006 SHALL have port we  input  1  write enable: 1 = store, 0 = load.
REQ-007 SHALL have port addr  input  7  word address.
REQ-008 SHALL have port wdata  input  16  store data.
REQ-009 SHALL have port ack  output  1  one-cycle response strobe.
REQ-010 SHALL have port rdata  output  16  load data, valid while ack=1 for a load.
REQ-011 SHALL have port busy  output  1  high from request capture until the ack cycle, inclusive.
REQ-012 SHALL have port err  output  1  address-range error, present only when DMEM_RESP_ERR_EN is defined.

Function
REQ-013 SHALL implement the states IDLE, WAIT and RESP.
REQ-014 SHALL, in IDLE with req=1 at a rising edge, latch addr, we and wdata, load the wait counter with WAIT_CYCLES, and enter WAIT, or enter RESP directly when WAIT_CYCLES=0.
REQ-015 SHALL, in WAIT, decrement the counter once per cycle and enter RESP on the edge where the counter equals 1.
REQ-016 SHALL assert ack for exactly the one RESP cycle, so that ack rises in cycle WAIT_CYCLES+1 when req is sampled high in cycle 0.
REQ-017 SHALL perform a store on the rising edge that ends the RESP cycle, using the latched address and data.
REQ-018 SHALL drive rdata during the RESP cycle of a load with the word at the latched address, and hold rdata until the next load response.
REQ-019 SHALL always return from RESP to IDLE.
REQ-020 SHALL sample req only in IDLE, so that a req held high yields back-to-back transactions separated by exactly one IDLE cycle.
REQ-021 SHALL ignore changes on req, we, addr and wdata during WAIT and RESP.
REQ-022 SHALL make a load in the cycle after a store to the same address return the new data (no stale read).
REQ-023 SHALL drive busy=1 in WAIT and RESP and busy=0 in IDLE.

Reset
REQ-024 SHALL, on rst=0 at a rising edge, enter IDLE, clear the wait counter and drive ack=0, busy=0, rdata=16'h0000 and err=0.
REQ-025 SHALL abort any in-flight transaction on reset, so that no store is committed and no ack is issued.
REQ-026 SHALL NOT clear storage contents on reset.

Configuration
REQ-027 SHALL, with DMEM_RESP_ERR_EN defined, treat any addr >= DEPTH as an error: ack asserted with err=1, rdata=16'h0000, and no store performed.
REQ-028 SHALL, without DMEM_RESP_ERR_EN, omit the err port and reduce the address modulo DEPTH, so that address 64 aliases to 0 and accesses behave normally.

Structure
REQ-029 SHALL place the state enum (IDLE/WAIT/RESP), DATA_W=16, ADDR_W=7 and the default DEPTH in the shared package dmem_resp_pkg.
REQ-030 SHALL place the storage array, with a single synchronous write port and a combinational read port, in the sub-module dmem_resp_array; the FSM, counter and output registers stay in dmem_responder.

Verification
REQ-031 SHALL cover: WAIT_CYCLES=2, store addr=5 wdata=16'hBEEF with req in cycle 0 -> ack=1 in cycle 3 only, busy=1 in cycles 1-3, and a later load of addr 5 returns 16'hBEEF.
REQ-032 SHALL cover: WAIT_CYCLES=0, req held high across a store to addr 9 (16'h1234) followed by a load of addr 9 -> ack in cycles 1 and 3, and rdata=16'h1234 in cycle 3.
REQ-033 SHALL cover: load addr=7 captured, then addr changed to 8 during WAIT -> rdata equals mem[7].
REQ-034 SHALL cover: store to addr 3 with rst=0 in cycle 2 of a WAIT_CYCLES=3 transaction -> no ack, busy=0, and mem[3] unchanged.
REQ-035 SHALL cover: with DMEM_RESP_ERR_EN, store addr=7'd70 -> ack=1, err=1, no store; without the macro, the same stimulus writes mem[6].
REQ-036 SHALL cover: after a reset following stores -> ack=0, rdata=0, and previously stored words still readable.
